// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Latency: out_valid XLEN+1 edges after accept (1 edge for divide-by-zero / signed overflow).
// Backpressure: single outstanding op; in_ready only in IDLE, result held until out_ready.
//
// Ports:
//   clk_in, rst_in (sync, active-high), flush_in (kills the op, result lost)
//   in_valid/in_ready  : op request (funct3, rs1, rs2, dst tag)
//   out_valid/out_ready: result (out_data, out_dst)
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_dst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_dst
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int              CW       = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state;
    logic [2:0]       op_q;
    logic [XLEN-1:0]  opnd_q;   // multiplicand (mul) or divisor (div), magnitude
    logic [XLEN-1:0]  hi_q;     // product high half / partial remainder
    logic [XLEN-1:0]  lo_q;     // multiplier bits / dividend bits then quotient
    logic             neg_q;
    logic [TAG_W-1:0] dst_q;
    logic [CW-1:0]    count;

    // ---------------- accept-time decode ----------------
    logic            sgn1, sgn2, acc_neg, div0, ovf, special;
    logic [XLEN-1:0] mag1, mag2, special_res;

    always_comb begin
        // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM.
        sgn1 = in_rs1[XLEN-1] && (in_funct3 == 3'd1 || in_funct3 == 3'd2 ||
                                  in_funct3 == 3'd4 || in_funct3 == 3'd6);
        sgn2 = in_rs2[XLEN-1] && (in_funct3 == 3'd1 || in_funct3 == 3'd4 ||
                                  in_funct3 == 3'd6);
        mag1 = sgn1 ? (~in_rs1 + 1'b1) : in_rs1;
        mag2 = sgn2 ? (~in_rs2 + 1'b1) : in_rs2;
        // Remainder takes the dividend's sign; everything else the xor.
        acc_neg = (in_funct3 == 3'd6) ? sgn1 : (sgn1 ^ sgn2);

        div0 = in_funct3[2] && (in_rs2 == '0);
        ovf  = in_funct3[2] && !in_funct3[0] && (in_rs1 == MOST_NEG) && (in_rs2 == '1);
        special = div0 || ovf;

        special_res = '0;
        if (div0)
            special_res = in_funct3[1] ? in_rs1 : '1;
        else if (ovf)
            special_res = in_funct3[1] ? '0 : in_rs1;
    end

    // ---------------- one iteration step ----------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_part;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   hi_n, lo_n;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   div_res, final_res;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_part = {hi_q, lo_q[XLEN-1]};
        div_ge   = div_part >= {1'b0, opnd_q};
        // When div_ge holds the difference is below the divisor, so XLEN bits suffice.
        div_diff = div_part[XLEN-1:0] - opnd_q;

        if (op_q[2]) begin
            hi_n = div_ge ? div_diff : div_part[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], div_ge};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
        end

        // Sign fix-up applies to the full product so the high half is right.
        prod_s  = neg_q ? (~{hi_n, lo_n} + 1'b1) : {hi_n, lo_n};
        div_res = op_q[1] ? hi_n : lo_n;
        if (neg_q)
            div_res = ~div_res + 1'b1;

        if (op_q[2])
            final_res = div_res;
        else if (op_q[1:0] == 2'd0)
            final_res = prod_s[XLEN-1:0];
        else
            final_res = prod_s[2*XLEN-1:XLEN];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dst   <= '0;
            count     <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            dst_q     <= '0;
        end else if (flush_in) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_q     <= in_funct3;
                        dst_q    <= in_dst;
                        neg_q    <= acc_neg;
                        count    <= '0;
                        in_ready <= 1'b0;
                        if (special) begin
                            out_data <= special_res;
                            out_dst  <= in_dst;
                            state    <= DONE;
                        end else begin
                            hi_q   <= '0;
                            lo_q   <= in_funct3[2] ? mag1 : mag2;
                            opnd_q <= in_funct3[2] ? mag2 : mag1;
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    hi_q  <= hi_n;
                    lo_q  <= lo_n;
                    count <= count + 1'b1;
                    // Last bit: the sign-corrected result goes straight to the output register.
                    if (count == LAST) begin
                        out_data <= final_res;
                        out_dst  <= dst_q;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // out_valid rises one edge after entering DONE, for both paths.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic RV32M reference model.
// Latency: checks XLEN+1 (normal) and 1 (special case) accept-to-valid edges.
// Backpressure: exercises output stalls, flush and mid-op reset.
module tb_muldiv_unit;

    logic        clk_in = 1'b0;
    logic        rst_in, flush_in, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1, in_rs2, out_data;
    logic [4:0]  in_dst, out_dst;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .flush_in (flush_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_funct3(in_funct3),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_dst   (in_dst),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_dst  (out_dst)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // RV32M semantics with plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (f3)
            3'd0: p = {32'h0, a} * {32'h0, b};
            3'd1: p = 64'(longint'(sa) * longint'(sb));
            3'd2: p = 64'(longint'(sa) * longint'({32'h0, b}));
            3'd3: p = {32'h0, a} * {32'h0, b};
            default: p = '0;
        endcase
        case (f3)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: return (b == 0) ? 32'hFFFFFFFF :
                         (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: return (b == 0) ? a :
                         (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 300));
            4: return -32'($urandom_range(1, 300));
            default: return $urandom;
        endcase
    endfunction

    // Issues one op, checks latency, result, tag, stall hold and drain.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want, input int stall);
        logic [4:0] dst;
        logic       sp;
        int         k;
        dst = 5'($urandom);
        sp  = f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
        check_eq("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_dst = dst;
        @(posedge clk_in); #1;
        in_valid = 1'b0; in_funct3 = 3'($urandom); in_rs1 = $urandom; in_rs2 = $urandom;
        in_dst = 5'($urandom);
        check_eq("in_ready_busy", 64'(in_ready), 64'd0);
        k = 0;
        while (!out_valid && k < 60) begin
            @(posedge clk_in); #1;
            k++;
        end
        check_eq($sformatf("latency f3=%0d", f3), 64'(k), sp ? 64'd1 : 64'd33);
        check_eq($sformatf("data f3=%0d a=%h b=%h", f3, a, b), 64'(out_data), 64'(want));
        check_eq("dst", 64'(out_dst), 64'(dst));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk_in); #1;
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_data", 64'(out_data), 64'(want));
            check_eq("hold_dst", 64'(out_dst), 64'(dst));
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk_in); #1;
        out_ready = 1'b0;
        check_eq("drain_valid", 64'(out_valid), 64'd0);
        check_eq("drain_in_ready", 64'(in_ready), 64'd1);
        check_eq("drain_keep_data", 64'(out_data), 64'(want));
    endtask

    // Starts a normal op, kills it after 10 busy cycles with flush or reset.
    task automatic kill_mid_op(input bit use_reset);
        in_valid = 1'b1; in_funct3 = 3'd5; in_rs1 = 32'd1000; in_rs2 = 32'd3; in_dst = 5'd9;
        @(posedge clk_in); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk_in);
        #1;
        if (use_reset) rst_in = 1'b1; else flush_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0; flush_in = 1'b0;
        check_eq(use_reset ? "rst_in_ready" : "flush_in_ready", 64'(in_ready), 64'd1);
        check_eq(use_reset ? "rst_valid" : "flush_valid", 64'(out_valid), 64'd0);
        if (use_reset) begin
            check_eq("rst_data", 64'(out_data), 64'd0);
            check_eq("rst_dst", 64'(out_dst), 64'd0);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in); #1;
            check_eq("killed_no_valid", 64'(out_valid), 64'd0);
        end
    endtask

    logic [2:0]  d_f3[12]  = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                               3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a[12]   = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                               32'd1234, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] d_b[12]   = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'd2, 32'd2, 32'd7, 32'd7,
                               32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] d_exp[12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                               32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                               32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};

    initial begin
        rst_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_dst = '0;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        check_eq("reset_in_ready", 64'(in_ready), 64'd1);
        check_eq("reset_out_valid", 64'(out_valid), 64'd0);
        check_eq("reset_out_data", 64'(out_data), 64'd0);
        check_eq("reset_out_dst", 64'(out_dst), 64'd0);

        // Directed cases; the first one also holds the result for 5 cycles.
        for (int i = 0; i < 12; i++)
            run_op(d_f3[i], d_a[i], d_b[i], d_exp[i], (i == 0) ? 5 : 0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 50; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom);
            a  = pick_operand();
            b  = pick_operand();
            run_op(f3, a, b, model(f3, a, b), $urandom_range(0, 3));
        end

        // Flush and reset in the middle of an op, each followed by a good op.
        kill_mid_op(1'b0);
        run_op(3'd1, 32'hFFFFFFF0, 32'd12345, model(3'd1, 32'hFFFFFFF0, 32'd12345), 1);
        kill_mid_op(1'b1);
        run_op(3'd6, 32'hFFFFFF9C, 32'd7, model(3'd6, 32'hFFFFFF9C, 32'd7), 0);

        // in_valid together with flush is not accepted.
        in_valid = 1'b1; flush_in = 1'b1; in_funct3 = 3'd4; in_rs1 = 32'd9; in_rs2 = 32'd0;
        @(posedge clk_in); #1;
        in_valid = 1'b0; flush_in = 1'b0;
        check_eq("flush_accept_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk_in); #1;
        check_eq("flush_accept_no_valid", 64'(out_valid), 64'd0);

        // Flush while a result waits for the consumer discards it.
        in_valid = 1'b1; in_funct3 = 3'd5; in_rs1 = 32'd3; in_rs2 = 32'd0; in_dst = 5'd4;
        @(posedge clk_in); #1;
        in_valid = 1'b0;
        @(posedge clk_in); #1;
        check_eq("done_valid", 64'(out_valid), 64'd1);
        flush_in = 1'b1; out_ready = 1'b1;
        @(posedge clk_in); #1;
        flush_in = 1'b0; out_ready = 1'b0;
        check_eq("done_flush_valid", 64'(out_valid), 64'd0);
        check_eq("done_flush_in_ready", 64'(in_ready), 64'd1);

        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
